// File: rtl/spi_sim_target_if.sv
// Pin and handshake bundle between the MCU-side SPI controller / host logic and the SPI target model.
// The master modport is the controller and host side; the slave modport is the target.
interface spi_sim_target_if;
    logic       sclk;
    logic       pico;
    logic       cs;
    logic       poci;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       overflow;
    logic       busy;

    modport master (
        output sclk, pico, cs, rx_ready, tx_data, tx_valid,
        input  poci, rx_data, rx_valid, tx_ready, overflow, busy
    );

    modport slave (
        input  sclk, pico, cs, rx_ready, tx_data, tx_valid,
        output poci, rx_data, rx_valid, tx_ready, overflow, busy
    );
endinterface

// File: rtl/spi_sim_target.sv
// SPI target model: oversampled SPI pins, RX byte FIFO, TX holding register plus shift register.
// Optional build macro SPI_SIM_TARGET_ECHO_EN echoes each received byte back on the next byte.
module spi_sim_target #(
    parameter int         CPOL       = 0,
    parameter int         CPHA       = 0,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] IDLE_BYTE  = 8'hFF
) (
    input  logic            clock,
    input  logic            reset,
    spi_sim_target_if.slave bus
);

    localparam int         AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic       IDLE_LVL = 1'(CPOL);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, state_nxt;

    // Stage p0/p1: two-flop synchronisers; p2: delayed copy for edge detection.
    // Left unreset so a cs held low across reset cannot look like a fresh falling edge.
    logic sclk_p0, sclk_p1, sclk_p2;
    logic pico_p0, pico_p1;
    logic cs_p0, cs_p1, cs_p2;

    always_ff @(posedge clock) begin
        sclk_p0 <= bus.sclk;
        sclk_p1 <= sclk_p0;
        sclk_p2 <= sclk_p1;
        pico_p0 <= bus.pico;
        pico_p1 <= pico_p0;
        cs_p0   <= bus.cs;
        cs_p1   <= cs_p0;
        cs_p2   <= cs_p1;
    end

    logic lead_edge, trail_edge, sample_edge, shift_edge, cs_fall, cs_rise;

    assign lead_edge   = (sclk_p1 != sclk_p2) && (sclk_p2 == IDLE_LVL);
    assign trail_edge  = (sclk_p1 != sclk_p2) && (sclk_p2 != IDLE_LVL);
    assign sample_edge = (CPHA == 0) ? lead_edge  : trail_edge;
    assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;
    assign cs_fall     = cs_p2 & ~cs_p1;
    assign cs_rise     = ~cs_p2 & cs_p1;

    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] rx_byte;
    logic [7:0] tx_shift;
    logic [7:0] hold;
    logic       hold_full;
    logic       skip_shift;
    logic       overflow_q;

    logic load_tx, sample_en, shift_en, push, skip_set;

    assign rx_byte = {rx_shift[6:0], pico_p1};

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // A reload arms skip_shift so the next shift edge leaves the fresh MSB on poci:
    // for CPHA=1 that is the leading edge of every byte, for CPHA=0 the trailing edge after bit 8.
    always_comb begin
        state_nxt = state;
        load_tx   = 1'b0;
        sample_en = 1'b0;
        shift_en  = 1'b0;
        push      = 1'b0;
        skip_set  = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nxt = ACTIVE;
                    load_tx   = 1'b1;
                    skip_set  = (CPHA != 0);
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                end else begin
                    sample_en = sample_edge;
                    shift_en  = shift_edge;
                    if (sample_edge && bit_cnt == 3'd7) begin
                        push     = 1'b1;
                        load_tx  = 1'b1;
                        skip_set = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    logic [7:0] refill;
`ifdef SPI_SIM_TARGET_ECHO_EN
    // The echoed byte passes straight through the empty holding register into the shifter.
    assign refill = push ? rx_byte : IDLE_BYTE;
`else
    assign refill = IDLE_BYTE;
`endif

    logic tx_accept;
    assign tx_accept = bus.tx_valid & ~hold_full;

    always_ff @(posedge clock) begin
        if (!reset) begin
            bit_cnt    <= 3'd0;
            rx_shift   <= 8'h00;
            tx_shift   <= IDLE_BYTE;
            hold       <= 8'h00;
            hold_full  <= 1'b0;
            skip_shift <= 1'b0;
        end else begin
            if (state == IDLE && cs_fall) begin
                bit_cnt <= 3'd0;
            end else if (sample_en) begin
                bit_cnt  <= bit_cnt + 3'd1;
                rx_shift <= rx_byte;
            end

            if (load_tx) begin
                skip_shift <= skip_set;
                if (hold_full) begin
                    tx_shift  <= hold;
                    hold_full <= 1'b0;
                end else begin
                    tx_shift <= refill;
                    if (tx_accept) begin
                        hold      <= bus.tx_data;
                        hold_full <= 1'b1;
                    end
                end
            end else begin
                if (shift_en) begin
                    if (skip_shift) skip_shift <= 1'b0;
                    else            tx_shift   <= {tx_shift[6:0], 1'b0};
                end
                if (tx_accept) begin
                    hold      <= bus.tx_data;
                    hold_full <= 1'b1;
                end
            end
        end
    end

    // RX FIFO: a pop in the same cycle as a push frees the slot first.
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, pop, push_ok;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign pop     = ~empty & bus.rx_ready;
    assign push_ok = push & (~full | pop);

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= rx_byte;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= push & full & ~pop;
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign bus.rx_valid = ~empty;
    assign bus.rx_data  = empty ? 8'h00 : mem[rd_ptr];
    assign bus.tx_ready = ~hold_full;
    assign bus.overflow = overflow_q;
    assign bus.busy     = (state == ACTIVE);
    assign bus.poci     = (state == ACTIVE) & tx_shift[7];

endmodule

// File: tb/tb_spi_sim_target.sv
// Scoreboard bench for spi_sim_target: a mode-0 and a mode-3 target driven by a behavioural SPI controller.
module tb_spi_sim_target;

    localparam int H = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    spi_sim_target_if bus0 ();
    spi_sim_target_if bus1 ();

    spi_sim_target #(.CPOL(0), .CPHA(0), .FIFO_DEPTH(4), .IDLE_BYTE(8'hFF)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0.slave));
    spi_sim_target #(.CPOL(1), .CPHA(1), .FIFO_DEPTH(4), .IDLE_BYTE(8'hFF)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1.slave));

    int n_tests = 0;
    int n_fail  = 0;
    int ovf_cnt [2];
    int ovf_exp [2];
    logic [7:0] rx_q [$];
    logic [7:0] miso_q [$];

`ifdef SPI_SIM_TARGET_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    initial begin
        ovf_cnt[0] = 0; ovf_cnt[1] = 0;
        ovf_exp[0] = 0; ovf_exp[1] = 0;
    end

    always @(posedge clock) begin
        if (bus0.overflow === 1'b1) ovf_cnt[0] <= ovf_cnt[0] + 1;
        if (bus1.overflow === 1'b1) ovf_cnt[1] <= ovf_cnt[1] + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_sclk(input int dev, input logic v);
        if (dev == 0) bus0.sclk = v; else bus1.sclk = v;
    endtask
    task automatic set_pico(input int dev, input logic v);
        if (dev == 0) bus0.pico = v; else bus1.pico = v;
    endtask
    task automatic set_cs(input int dev, input logic v);
        if (dev == 0) bus0.cs = v; else bus1.cs = v;
    endtask
    task automatic set_rx_ready(input int dev, input logic v);
        if (dev == 0) bus0.rx_ready = v; else bus1.rx_ready = v;
    endtask

    function automatic logic get_poci(input int dev);
        return (dev == 0) ? bus0.poci : bus1.poci;
    endfunction
    function automatic logic get_rx_valid(input int dev);
        return (dev == 0) ? bus0.rx_valid : bus1.rx_valid;
    endfunction
    function automatic logic [7:0] get_rx_data(input int dev);
        return (dev == 0) ? bus0.rx_data : bus1.rx_data;
    endfunction
    function automatic logic get_tx_ready(input int dev);
        return (dev == 0) ? bus0.tx_ready : bus1.tx_ready;
    endfunction
    function automatic logic get_busy(input int dev);
        return (dev == 0) ? bus0.busy : bus1.busy;
    endfunction

    // Controller bit engine; dev 0 is mode 0, dev 1 is mode 3.
    task automatic spi_bits(input int dev, input logic [7:0] mosi, input int nbits,
                            output logic [7:0] miso);
        logic cpol;
        cpol = (dev == 1);
        miso = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (dev == 0) begin
                set_pico(dev, mosi[7-i]);
                wait_clk(H);
                miso = {miso[6:0], get_poci(dev)};
                set_sclk(dev, ~cpol);
                wait_clk(H);
                set_sclk(dev, cpol);
            end else begin
                set_sclk(dev, ~cpol);
                set_pico(dev, mosi[7-i]);
                wait_clk(H);
                miso = {miso[6:0], get_poci(dev)};
                set_sclk(dev, cpol);
                wait_clk(H);
            end
        end
    endtask

    task automatic cs_low(input int dev);
        set_cs(dev, 1'b0);
        wait_clk(H);
    endtask

    task automatic cs_high(input int dev);
        wait_clk(H);
        set_cs(dev, 1'b1);
        wait_clk(H);
    endtask

    task automatic xfer(input int dev, input logic [7:0] mosi, input logic [7:0] exp_miso);
        logic [7:0] got;
        miso_q.push_back(exp_miso);
        if (rx_q.size() < 4) rx_q.push_back(mosi);
        else                 ovf_exp[dev]++;
        spi_bits(dev, mosi, 8, got);
        check("miso", {24'h0, got}, {24'h0, miso_q.pop_front()});
    endtask

    task automatic preload(input int dev, input logic [7:0] data);
        int guard = 0;
        while (get_tx_ready(dev) !== 1'b1 && guard < 50) begin
            wait_clk(1);
            guard++;
        end
        if (dev == 0) begin bus0.tx_data = data; bus0.tx_valid = 1'b1; end
        else          begin bus1.tx_data = data; bus1.tx_valid = 1'b1; end
        wait_clk(1);
        if (dev == 0) bus0.tx_valid = 1'b0; else bus1.tx_valid = 1'b0;
        check("tx_ready_after_load", {31'h0, get_tx_ready(dev)}, 32'h0);
    endtask

    task automatic drain(input int dev);
        int guard = 0;
        while (rx_q.size() > 0 && guard < 100) begin
            if (get_rx_valid(dev) === 1'b1) begin
                check("rx_data", {24'h0, get_rx_data(dev)}, {24'h0, rx_q.pop_front()});
                set_rx_ready(dev, 1'b1);
                wait_clk(1);
                set_rx_ready(dev, 1'b0);
            end else begin
                wait_clk(1);
            end
            guard++;
        end
        check("rx_drained", rx_q.size(), 32'h0);
        rx_q.delete();
        check("rx_empty", {31'h0, get_rx_valid(dev)}, 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] dummy;
        bus0.sclk = 1'b0; bus0.pico = 1'b0; bus0.cs = 1'b1;
        bus0.rx_ready = 1'b0; bus0.tx_data = 8'h00; bus0.tx_valid = 1'b0;
        bus1.sclk = 1'b1; bus1.pico = 1'b0; bus1.cs = 1'b1;
        bus1.rx_ready = 1'b0; bus1.tx_data = 8'h00; bus1.tx_valid = 1'b0;

        reset = 1'b0;
        wait_clk(5);
        check("rst_poci",     {31'h0, bus0.poci},     32'h0);
        check("rst_rx_valid", {31'h0, bus0.rx_valid}, 32'h0);
        check("rst_rx_data",  {24'h0, bus0.rx_data},  32'h0);
        check("rst_tx_ready", {31'h0, bus0.tx_ready}, 32'h1);
        check("rst_overflow", {31'h0, bus0.overflow}, 32'h0);
        check("rst_busy",     {31'h0, bus0.busy},     32'h0);
        reset = 1'b1;
        wait_clk(3);

        // Preloaded reply byte
        preload(0, 8'h3C);
        cs_low(0);
        check("busy_active", {31'h0, get_busy(0)}, 32'h1);
        xfer(0, 8'hA5, 8'h3C);
        cs_high(0);
        check("tx_ready_refilled", {31'h0, get_tx_ready(0)}, 32'h1);
        check("busy_idle", {31'h0, get_busy(0)}, 32'h0);
        drain(0);

        // Empty holding register sends IDLE_BYTE
        cs_low(0);
        xfer(0, 8'h00, 8'hFF);
        cs_high(0);
        check("tx_ready_idle", {31'h0, get_tx_ready(0)}, 32'h1);
        drain(0);

        // FIFO overflow on the fifth byte
        cs_low(0);
        for (int i = 1; i <= 5; i++)
            xfer(0, 8'(i), (ECHO && i > 1) ? 8'(i - 1) : 8'hFF);
        cs_high(0);
        check("overflow_pulses", ovf_cnt[0], ovf_exp[0]);
        drain(0);

        // Aborted partial byte is discarded
        cs_low(0);
        spi_bits(0, 8'hF0, 5, dummy);
        cs_high(0);
        wait_clk(H);
        check("partial_no_push", {31'h0, get_rx_valid(0)}, 32'h0);
        cs_low(0);
        xfer(0, 8'h81, 8'hFF);
        cs_high(0);
        drain(0);

        // Mode 3 target
        preload(1, 8'hC3);
        cs_low(1);
        xfer(1, 8'h5A, 8'hC3);
        cs_high(1);
        drain(1);

        // Reset mid-transfer: clocks while cs stays low must be ignored
        cs_low(0);
        spi_bits(0, 8'hE0, 3, dummy);
        reset = 1'b0;
        wait_clk(2);
        reset = 1'b1;
        wait_clk(2);
        check("midrst_busy", {31'h0, get_busy(0)}, 32'h0);
        spi_bits(0, 8'h77, 8, dummy);
        wait_clk(H);
        check("midrst_poci", {31'h0, get_poci(0)}, 32'h0);
        check("midrst_no_push", {31'h0, get_rx_valid(0)}, 32'h0);
        cs_high(0);
        cs_low(0);
        xfer(0, 8'h66, 8'hFF);
        cs_high(0);
        drain(0);

`ifdef SPI_SIM_TARGET_ECHO_EN
        cs_low(0);
        xfer(0, 8'h12, 8'hFF);
        xfer(0, 8'h34, 8'h12);
        cs_high(0);
        drain(0);
`endif

        check("overflow_total_dut0", ovf_cnt[0], ovf_exp[0]);
        check("overflow_total_dut1", ovf_cnt[1], ovf_exp[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
